// File: rtl/ntt_ram_sequencer_if.sv
// Bundle between the NTT RAM sequencer, the dual-port coefficient RAM and the butterfly unit.
// master = sequencer side, slave = RAM/butterfly/controller side.
interface ntt_ram_sequencer_if #(
  parameter int DW = 12,
  parameter int AW = 8
);
  logic          start;
  logic          inv;
  logic          busy;
  logic          done;
  logic          we_a;
  logic          we_b;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;
  logic [DW-1:0] q_a;
  logic [DW-1:0] q_b;
  logic          bf_valid;
  logic [DW-1:0] bf_u;
  logic [DW-1:0] bf_v;
  logic [6:0]    bf_zeta_idx;
  logic          bf_inv;
  logic          bf_res_valid;
  logic [DW-1:0] bf_res_u;
  logic [DW-1:0] bf_res_v;

  modport master (
    input  start, inv, q_a, q_b, bf_res_valid, bf_res_u, bf_res_v,
    output busy, done, we_a, we_b, addr_a, addr_b, data_a, data_b,
           bf_valid, bf_u, bf_v, bf_zeta_idx, bf_inv
  );

  modport slave (
    output start, inv, q_a, q_b, bf_res_valid, bf_res_u, bf_res_v,
    input  busy, done, we_a, we_b, addr_a, addr_b, data_a, data_b,
           bf_valid, bf_u, bf_v, bf_zeta_idx, bf_inv
  );
endinterface

// File: rtl/ntt_ram_sequencer.sv
// Walks the full 256-point Kyber NTT / inverse NTT butterfly schedule over a dual-port RAM,
// one butterfly in flight: read pair, hand to butterfly unit, wait, write pair back.
//
// state | meaning
// IDLE  | waiting for start, outputs parked at 0
// RD    | addresses j / j+len presented, RAM read in progress
// OP    | RAM data valid, operands pushed to butterfly unit
// WT    | waiting for butterfly result, captured on bf_res_valid
// WR    | both results written back, schedule advanced
module ntt_ram_sequencer #(
  parameter int DW = 12,
  parameter int AW = 8
) (
  input  logic                clk,
  input  logic                rst,
  ntt_ram_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD, OP, WT, WR} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] j_q, j_d;
  logic [AW-1:0] addr_b_q, addr_b_d;
  logic [AW-1:0] len_q, len_d;
  logic [6:0]    k_q, k_d;
  logic          inv_q, inv_d;
  logic [DW-1:0] u_q, u_d;
  logic [DW-1:0] v_q, v_d;
  logic [DW-1:0] da_q, da_d;
  logic [DW-1:0] db_q, db_d;
  logic          done_q, done_d;

  logic [AW:0]   j_nx;
  logic [AW:0]   grp_nx;
  logic [AW-1:0] len_nx;
  logic [6:0]    k_nx;
  logic          group_end;
  logic          last_stage;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      j_q      <= '0;
      addr_b_q <= '0;
      len_q    <= '0;
      k_q      <= '0;
      inv_q    <= 1'b0;
      u_q      <= '0;
      v_q      <= '0;
      da_q     <= '0;
      db_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      addr_b_q <= addr_b_d;
      len_q    <= len_d;
      k_q      <= k_d;
      inv_q    <= inv_d;
      u_q      <= u_d;
      v_q      <= v_d;
      da_q     <= da_d;
      db_q     <= db_d;
      done_q   <= done_d;
    end
  end

  // Groups are aligned to 2*len, so j+1 landing on a multiple of len closes the group.
  always_comb begin
    j_nx       = {1'b0, j_q} + 9'd1;
    grp_nx     = j_nx + {1'b0, len_q};
    group_end  = (j_nx[AW-1:0] & (len_q - 8'd1)) == '0;
    last_stage = inv_q ? (len_q == 8'd128) : (len_q == 8'd2);
    len_nx     = inv_q ? (len_q << 1) : (len_q >> 1);
    k_nx       = inv_q ? (k_q - 7'd1) : (k_q + 7'd1);
  end

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    addr_b_d = addr_b_q;
    len_d    = len_q;
    k_d      = k_q;
    inv_d    = inv_q;
    u_d      = u_q;
    v_d      = v_q;
    da_d     = da_q;
    db_d     = db_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RD;
          inv_d    = bus.inv;
          j_d      = '0;
          len_d    = bus.inv ? 8'd2 : 8'd128;
          addr_b_d = bus.inv ? 8'd2 : 8'd128;
          k_d      = bus.inv ? 7'd127 : 7'd1;
        end
      end
      RD: state_d = OP;
      OP: begin
        state_d = WT;
        u_d     = bus.q_a;
        v_d     = bus.q_b;
      end
      WT: begin
        if (bus.bf_res_valid) begin
          state_d = WR;
          da_d    = bus.bf_res_u;
          db_d    = bus.bf_res_v;
        end
      end
      WR: begin
        state_d = RD;
        if (!group_end) begin
          j_d      = j_nx[AW-1:0];
          addr_b_d = j_nx[AW-1:0] + len_q;
        end else begin
          k_d = k_nx;
          if (!grp_nx[AW]) begin
            j_d      = grp_nx[AW-1:0];
            addr_b_d = grp_nx[AW-1:0] + len_q;
          end else if (last_stage) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            j_d      = '0;
            addr_b_d = '0;
            len_d    = '0;
            k_d      = '0;
          end else begin
            j_d      = '0;
            len_d    = len_nx;
            addr_b_d = len_nx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands come straight from the RAM in OP and are held from the capture afterwards.
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.we_a        = (state_q == WR);
  assign bus.we_b        = (state_q == WR);
  assign bus.addr_a      = j_q;
  assign bus.addr_b      = addr_b_q;
  assign bus.data_a      = da_q;
  assign bus.data_b      = db_q;
  assign bus.bf_valid    = (state_q == OP);
  assign bus.bf_u        = (state_q == OP) ? bus.q_a : u_q;
  assign bus.bf_v        = (state_q == OP) ? bus.q_b : v_q;
  assign bus.bf_zeta_idx = k_q;
  assign bus.bf_inv      = inv_q;

endmodule

// File: doc/ntt_ram_sequencer.md
# ntt_ram_sequencer

Memory-side initiator for the 256×12-bit true dual-port coefficient RAM in the Kyber NTT accelerator. On `start` it walks one complete in-place NTT (Cooley-Tukey) or inverse NTT (Gentleman-Sande) schedule: for each butterfly it reads the operand pair through both RAM ports, hands the pair and zeta index to the butterfly unit, waits for the result, and writes both results back through both ports. It owns both RAM ports while `busy`, and is strictly serial, one butterfly in flight, so there are no read/write address hazards.

## Interface
- `DW`, 12, coefficient width.
- `AW`, 8, RAM address width (256 coefficients; the schedule is fixed for 256).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin transform; sampled only in IDLE.
- `inv`  in  1  0 = forward NTT, 1 = inverse NTT; sampled with `start`.
- `busy`  out  1  high from the cycle after accepted `start` through the final WR cycle.
- `done`  out  1  one-cycle pulse in the cycle after the final WR.
- `we_a`, `we_b`  out  1  RAM write enables, ports A/B.
- `addr_a`, `addr_b`  out  AW  RAM addresses; A = j, B = j+len.
- `data_a`, `data_b`  out  DW  RAM write data.
- `q_a`, `q_b`  in  DW  RAM read data, registered in RAM, valid the cycle after the address.
- `bf_valid`  out  1  operands valid, one-cycle pulse per butterfly.
- `bf_u`, `bf_v`  out  DW  operands (u from port A, v from port B).
- `bf_zeta_idx`  out  7  zeta table index, 1..127.
- `bf_inv`  out  1  latched `inv`, selects CT/GS butterfly.
- `bf_res_valid`  in  1  result valid.
- `bf_res_u`, `bf_res_v`  in  DW  results; u to address j, v to address j+len.

## Operation
- States: IDLE, RD, OP, WT, WR.
- IDLE→RD on `start`. `start` is ignored in every other state.
- RD→OP always. RD drives `addr_a`=j and `addr_b`=j+len with `we_a`=`we_b`=0.
- OP→WT always. In OP, `bf_valid`=1 and `bf_u`/`bf_v`=`q_a`/`q_b`.
- WT holds until `bf_res_valid`=1. In that cycle it captures the results into `data_a`/`data_b`, then goes to WR.
- `bf_res_valid` outside WT is ignored.
- WR drives `we_a`=`we_b`=1 to the same addresses. WR→RD for the next butterfly, or WR→IDLE with `done` after the last butterfly.
- Addresses and `bf_zeta_idx` are registered and held constant from RD through WR.
- Forward schedule:
  - k starts at 1; len = 128, 64, …, 2 (7 stages).
  - Groups start at 0, 2·len, 4·len, …; k increments once per group.
  - j runs from the group start to group start + len − 1.
- Inverse schedule:
  - k starts at 127; len = 2, 4, …, 128.
  - Groups as above; k decrements once per group.
- Every stage has 128 butterflies, so there are 896 butterflies in total.
- Forward first/last butterfly: (0,128,k=1) / (253,255,k=127).
- Inverse first/last butterfly: (0,2,k=127) / (127,255,k=1).
- All index arithmetic is unsigned. j+len never exceeds 255, so there is no wrap.
- When not `busy`: `we_a`/`we_b`=0, addresses held at 0, `bf_valid`=0.
- Reset values: state IDLE; all outputs 0, including `bf_u`/`bf_v`, `data_*`, `bf_zeta_idx` and `bf_inv`.
- `rst` mid-transform: next cycle is IDLE with all outputs 0. No write is issued, no `done` is produced, and the partial RAM contents are left as is.
- `rst` and `start` together: `rst` wins.

## Timing
- `start` high at edge 0 → RD in cycle 1 (`busy`=1), OP in cycle 2, WT from cycle 3.
- Butterfly cost = 3 + W cycles, where W ≥ 1 is the number of WT cycles including the one with `bf_res_valid`.
- With W=1 every time: 4 cycles per butterfly. The last WR is in cycle 3584, `done`=1 and `busy`=0 in cycle 3585, and a new `start` is accepted in cycle 3585.
- The WR write and the next RD read of the same address are in consecutive cycles. The RAM's write-first behaviour makes this safe.

## Test plan
- Forward address trace, identity butterfly (res = operands, W=1):
  - butterfly 1 is (0,128,k1) and butterfly 2 is (1,129,k1);
  - stage 2 begins (0,64,k2); butterfly 65 is (128,192,k3);
  - the last is (253,255,k127); `done` arrives in cycle 3585;
  - RAM contents are unchanged.
- Inverse trace:
  - first (0,2,k127), then (1,3,k127), then (4,6,k126);
  - the last is (127,255,k1); `bf_inv`=1 throughout.
- Variable latency: W randomized 1..5. Addresses, `bf_u`/`bf_v` and the write data stay stable through WT. Results given as u+1 and v+2 (mod 4096) land at the correct addresses; the final RAM matches the golden model.
- `start` pulsed in RD/OP/WT/WR during a transform → ignored, and the trace is identical to the unperturbed run.
- `rst` asserted in WT of butterfly 300 → next cycle all outputs are 0, no write and no `done`; a fresh `start` restarts at (0,128,k1).
- Spurious `bf_res_valid` in RD/OP → no state change and no write.
